// File: rtl/demux_stream.sv
// Registered 1-to-N valid/ready stream demultiplexer with broadcast mode,
// a one-entry output buffer per channel and a saturating drop counter.
module demux_stream #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int CNT_W  = 8,
    localparam int SEL_W = (N_CH == 1) ? 1 : $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic [N_CH-1:0]          chan_en,
    output logic [N_CH-1:0]          out_valid,
    input  logic [N_CH-1:0]          out_ready,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

    logic [N_CH-1:0]   buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] buf_data_q [N_CH];
    logic [DATA_W-1:0] buf_data_d [N_CH];
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [N_CH-1:0] tgt;
    logic [N_CH-1:0] free;
    logic            sel_ok;
    logic            accept;

    // A beat is accepted only when every targeted channel can take it,
    // which makes broadcast all-or-nothing.
    always_comb begin
        sel_ok = ({1'b0, in_sel} < N_CH_L);
        for (int k = 0; k < N_CH; k++) begin
            free[k] = !buf_valid_q[k] || out_ready[k];
            tgt[k]  = chan_en[k] && (in_bcast || (sel_ok && (in_sel == SEL_W'(k))));
        end
        in_ready = &(free | ~tgt);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        drop_cnt_d  = drop_cnt_q;
        for (int k = 0; k < N_CH; k++) begin
            if (accept && tgt[k]) begin
                buf_valid_d[k] = 1'b1;
                buf_data_d[k]  = in_data;
            end else if (buf_valid_q[k] && out_ready[k]) begin
                buf_valid_d[k] = 1'b0;
            end
        end
        if (accept && (tgt == '0) && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= '0;
            drop_cnt_q  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                buf_data_q[k] <= '0;
            end
        end else begin
            buf_valid_q <= buf_valid_d;
            drop_cnt_q  <= drop_cnt_d;
            for (int k = 0; k < N_CH; k++) begin
                buf_data_q[k] <= buf_data_d[k];
            end
        end
    end

    always_comb begin
        out_valid = buf_valid_q;
        drop_cnt  = drop_cnt_q;
        for (int k = 0; k < N_CH; k++) begin
            out_data[k*DATA_W +: DATA_W] = buf_data_q[k];
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios followed by random
// traffic, all compared against a per-channel behavioural model.
module tb_demux_stream;

    localparam int DATA_W  = 8;
    localparam int N_CH    = 6;
    localparam int CNT_W   = 3;
    localparam int SEL_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_bcast;
    logic [N_CH-1:0]        chan_en;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH-1:0]        out_ready;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [CNT_W-1:0]       drop_cnt;

    int total = 0;
    int bad   = 0;

    bit              m_valid [N_CH];
    logic [DATA_W-1:0] m_data [N_CH];
    int              m_drop;

    demux_stream #(.DATA_W(DATA_W), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_bcast(in_bcast), .chan_en(chan_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit modelTarget(int k);
        if (!chan_en[k]) return 1'b0;
        if (in_bcast) return 1'b1;
        return int'(in_sel) == k;
    endfunction

    function automatic bit modelReady();
        for (int k = 0; k < N_CH; k++) begin
            if (modelTarget(k) && m_valid[k] && !out_ready[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < N_CH; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end
        m_drop = 0;
    endtask

    task automatic modelClock();
        bit acc;
        bit stored;
        if (!rst_n) return;
        acc    = in_valid && modelReady();
        stored = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (acc && modelTarget(k)) begin
                m_valid[k] = 1'b1;
                m_data[k]  = in_data;
                stored     = 1'b1;
            end else if (m_valid[k] && out_ready[k]) begin
                m_valid[k] = 1'b0;
            end
        end
        if (acc && !stored && m_drop < CNT_MAX) m_drop++;
    endtask

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [N_CH-1:0]        ev;
        logic [N_CH*DATA_W-1:0] ed;
        for (int k = 0; k < N_CH; k++) begin
            ev[k] = m_valid[k];
            ed[k*DATA_W +: DATA_W] = m_data[k];
        end
        checkValue({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        checkValue({tag, ".out_data"}, 64'(out_data), 64'(ed));
        checkValue({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
        checkValue({tag, ".in_ready"}, 64'(in_ready), 64'(modelReady()));
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s,
                                 input logic b, input logic [N_CH-1:0] en, input logic [N_CH-1:0] rdy);
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        in_bcast  = b;
        chan_en   = en;
        out_ready = rdy;
    endtask

    task automatic stepCycle(input string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        modelClock();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        modelReset();
        applyStimulus(1'b1, 8'hEE, 3'd0, 1'b0, '1, '1);
        repeat (3) stepCycle("reset");
        checkValue("reset.valid", 64'(out_valid), 64'd0);
        checkValue("reset.drop", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, '1, '1);
        stepCycle("idle");

        applyStimulus(1'b1, 8'h11, 3'd2, 1'b0, '1, '1);
        stepCycle("uni0");
        checkValue("uni.valid0", 64'(out_valid), 64'(6'b000100));
        checkValue("uni.data0", 64'(out_data[2*DATA_W +: DATA_W]), 64'h11);
        applyStimulus(1'b1, 8'h22, 3'd2, 1'b0, '1, '1);
        stepCycle("uni1");
        checkValue("uni.data1", 64'(out_data[2*DATA_W +: DATA_W]), 64'h22);
        applyStimulus(1'b1, 8'h33, 3'd2, 1'b0, '1, '1);
        stepCycle("uni2");
        checkValue("uni.data2", 64'(out_data[2*DATA_W +: DATA_W]), 64'h33);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, '1, '1);
        repeat (2) stepCycle("uni_drain");

        applyStimulus(1'b1, 8'hA5, 3'd1, 1'b0, '1, 6'b111101);
        stepCycle("bp_load");
        applyStimulus(1'b1, 8'h3C, 3'd1, 1'b0, '1, 6'b111101);
        repeat (2) stepCycle("bp_stall");
        checkValue("bp.ready_low", 64'(in_ready), 64'd0);
        checkValue("bp.hold", 64'(out_data[1*DATA_W +: DATA_W]), 64'hA5);
        applyStimulus(1'b1, 8'h3C, 3'd1, 1'b0, '1, '1);
        #1;
        checkValue("bp.ready_high", 64'(in_ready), 64'd1);
        stepCycle("bp_release");
        checkValue("bp.second", 64'(out_data[1*DATA_W +: DATA_W]), 64'h3C);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, '1, '1);
        stepCycle("bp_drain");

        applyStimulus(1'b1, 8'h77, 3'd1, 1'b0, 6'b001011, 6'b111101);
        stepCycle("bc_fill");
        applyStimulus(1'b1, 8'h5A, 3'd0, 1'b1, 6'b001011, 6'b111101);
        repeat (2) stepCycle("bc_stall");
        checkValue("bc.ready_low", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 8'h5A, 3'd0, 1'b1, 6'b001011, '1);
        stepCycle("bc_go");
        checkValue("bc.valid", 64'(out_valid), 64'(6'b001011));
        checkValue("bc.data0", 64'(out_data[0 +: DATA_W]), 64'h5A);
        checkValue("bc.data1", 64'(out_data[1*DATA_W +: DATA_W]), 64'h5A);
        checkValue("bc.data3", 64'(out_data[3*DATA_W +: DATA_W]), 64'h5A);
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, '1, '1);
        stepCycle("bc_drain");

        applyStimulus(1'b1, 8'h01, 3'd1, 1'b0, 6'b111101, '1);
        stepCycle("drop_dis1");
        applyStimulus(1'b1, 8'h02, 3'd5, 1'b0, 6'b011111, '1);
        stepCycle("drop_dis5");
        checkValue("drop.two", 64'(drop_cnt), 64'd2);
        checkValue("drop.no_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 8'h03, 3'd6, 1'b0, '1, '1);
        stepCycle("drop_range6");
        applyStimulus(1'b1, 8'h04, 3'd0, 1'b1, '0, '1);
        stepCycle("drop_bcast_none");
        applyStimulus(1'b1, 8'h05, 3'd7, 1'b0, '1, '1);
        repeat (5) stepCycle("drop_sat");
        checkValue("drop.saturated", 64'(drop_cnt), 64'(CNT_MAX));
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, '1, '1);
        stepCycle("drop_idle");

        applyStimulus(1'b1, 8'hC0, 3'd0, 1'b0, '1, '0);
        stepCycle("rst_fill0");
        applyStimulus(1'b1, 8'hC3, 3'd3, 1'b0, '1, '0);
        stepCycle("rst_fill3");
        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, '1, '0);
        checkValue("rst.full", 64'(out_valid), 64'(6'b001001));
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkValue("rst.async_valid", 64'(out_valid), 64'd0);
        checkValue("rst.async_data", 64'(out_data), 64'd0);
        checkValue("rst.async_drop", 64'(drop_cnt), 64'd0);
        stepCycle("rst_held");
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'hD0, 3'd0, 1'b0, '1, '1);
        stepCycle("rst_after");
        checkValue("rst.new_valid", 64'(out_valid), 64'(6'b000001));
        checkValue("rst.new_data", 64'(out_data[0 +: DATA_W]), 64'hD0);

        chan_en = '1;
        for (int i = 0; i < 400; i++) begin
            logic [N_CH-1:0] en;
            en = chan_en;
            if ($urandom_range(0, 15) == 0) en = N_CH'($urandom);
            applyStimulus(1'($urandom), DATA_W'($urandom), SEL_W'($urandom_range(0, 7)),
                          ($urandom_range(0, 7) == 0), en, N_CH'($urandom));
            stepCycle("rand");
        end

        applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, '1, '1);
        repeat (2) stepCycle("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised registered 1-to-N stream demultiplexer: successor to the combinational 1-to-4 demux.
- Routes each input beat to the selected output channel, or to all enabled channels in broadcast mode.
- Uses valid/ready handshakes and a one-entry output register per channel.
- Beats addressed to an out-of-range or disabled channel are dropped and counted.

Parameters:
- DATA_W, 8, payload width in bits.
- N_CH, 4, number of output channels (1..16).
- CNT_W, 8, width of the saturating drop counter.
- SEL_W (localparam), N_CH==1 ? 1 : clog2(N_CH), width of the channel select.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid is also high.
- in_data  input  DATA_W  input payload.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1: send the beat to every enabled channel; in_sel is ignored.
- chan_en  input  N_CH  per-channel enable mask.
- out_valid  output  N_CH  per-channel beat present.
- out_ready  input  N_CH  per-channel consumer ready.
- out_data  output  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- drop_cnt  output  CNT_W  number of dropped beats; saturates at all-ones.

Behaviour:
- Reset (asynchronous, rst_n=0): all buffer valid bits 0, all buffer data 0, drop_cnt 0. Consequently out_valid=0 and out_data=0 while reset is asserted and after release.
- Per-channel buffer: out_valid[k] is buf_valid[k]; out_data slice k is buf_data[k]. Both are driven directly from flops, with no combinational path from the input.
- free[k] = !buf_valid[k] || out_ready[k].
- Target mask tgt:
  - in_bcast=1: tgt = chan_en.
  - in_bcast=0 and in_sel < N_CH: tgt = onehot(in_sel) & chan_en.
  - Otherwise: tgt = 0.
- in_ready = AND over k of (free[k] || !tgt[k]). It is combinational from out_ready, chan_en, in_sel and in_bcast. It does not depend on in_valid.
- accept = in_valid && in_ready.
- Broadcast is all-or-nothing: no targeted channel is loaded unless every targeted channel is free in the same cycle.
- Per-channel update each clock:
  - If accept && tgt[k]: buf_valid[k] <= 1 and buf_data[k] <= in_data. This takes priority and covers simultaneous drain and load, giving full throughput.
  - Else if buf_valid[k] && out_ready[k]: buf_valid[k] <= 0. buf_data[k] holds its value.
  - Else: hold.
- Latency: a beat accepted at edge t is visible on out_valid/out_data after edge t, i.e. one cycle.
- Throughput: one beat per cycle per channel while out_ready is held high.
- Drop: if accept && tgt==0, the beat is consumed (in_ready=1) and not stored. drop_cnt increments by 1 and holds at 2^CNT_W-1.
- Ordering: each channel delivers beats in acceptance order.
- Valid-side rules:
  - Once out_valid[k]=1, buf_data[k] stays stable until it is consumed.
  - out_valid[k] never drops without a handshake, except on reset.
- chan_en changes affect only future accepts. Beats already buffered in a now-disabled channel are still delivered.
- Reset mid-operation: buffered beats are discarded and drop_cnt clears. No beat is emitted during reset.
- Upstream contract: in_data, in_sel and in_bcast are held stable while in_valid=1 && in_ready=0. Violating this is legal, but only the values present on the accepting cycle are used.

Test Plan:
- Reset then idle. Hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, drop_cnt=0, and no buffer loads until rst_n=1.
- Unicast streaming. N_CH=4, chan_en=4'b1111, out_ready=4'b1111, send 0x11,0x22,0x33 to in_sel=2 on back-to-back cycles -> out_valid[2] is high for 3 consecutive cycles starting 1 cycle later with data 0x11,0x22,0x33; in_ready stays 1; other channels stay 0.
- Backpressure. out_ready[1]=0 with a beat 0xA5 buffered on channel 1, then send a second beat to sel=1 -> in_ready=0 and 0xA5 stays stable. Raise out_ready[1] -> in_ready=1 in that same cycle; the next edge loads the second beat while 0xA5 is consumed.
- Broadcast all-or-nothing. chan_en=4'b1011, out_ready=4'b1101, channel 1 full, send bcast 0x5A -> in_ready=0. Release out_ready[1] -> out_valid becomes 4'b1011, all carrying 0x5A; channel 2 is untouched.
- Drops. Send sel=1 with chan_en[1]=0, then sel=5 with N_CH=6 and chan_en[5]=0 -> in_ready=1, no out_valid change, drop_cnt=2. With CNT_W=2, send 5 drops -> drop_cnt=3 (saturated).
- Reset mid-operation. Channels 0 and 3 full with out_ready=0, pulse rst_n=0 asynchronously between edges -> out_valid=0 immediately. After release, a new beat to channel 0 appears normally with a 1-cycle latency.
